// File: rtl/data_mem_ctrl_pkg.sv
// data_mem_ctrl_pkg: controller-local state encoding.
package data_mem_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, WRITE, READ_WAIT, READ_DONE} ctrl_state_t;
endpackage

// File: rtl/mem_pkg.sv
// mem: shared memory-bus width encoding and byte-lane helpers.
package mem;
  typedef enum logic [1:0] {BYTE = 2'd0, WORD = 2'd1, DWORD = 2'd2} mem_width_t;
  function automatic logic [3:0] lane_we(mem_width_t w, logic [1:0] off);
    return w == BYTE ? 4'b0001 << off : w == WORD ? 4'b0011 << {off[1], 1'b0} : 4'b1111;
  endfunction
  function automatic logic [31:0] lane_extract(mem_width_t w, logic [1:0] off, logic [31:0] d);
    return w == BYTE ? {24'b0, d[8*off +: 8]} : w == WORD ? {16'b0, d[16*off[1] +: 16]} : d;
  endfunction
endpackage

// File: rtl/mem_bus_if.sv
// mem_bus_if: CPU MEM-stage to data-memory handshake bus.
interface mem_bus_if;
  import mem::*;
  logic        dispatch_read;
  logic        dispatch_write;
  logic [31:0] addr;
  mem_width_t  mem_width;
  logic [31:0] write_data;
  logic        busy;
  logic [31:0] read_data;
  modport master(output dispatch_read, dispatch_write, addr, mem_width, write_data, input busy, read_data);
  modport slave(input dispatch_read, dispatch_write, addr, mem_width, write_data, output busy, read_data);
endinterface

// File: rtl/mem_lane_steer.sv
// mem_lane_steer: byte-lane write enables/replication and zero-extended load extraction.
module mem_lane_steer
  import mem::*;
(
  input  mem_width_t  width,
  input  logic [1:0]  off,
  input  logic [31:0] wd,
  input  logic [31:0] dout,
  output logic [3:0]  we,
  output logic [31:0] din,
  output logic [31:0] rd
);
  assign we  = lane_we(width, off);
  assign din = width == BYTE ? {4{wd[7:0]}} : width == WORD ? {2{wd[15:0]}} : wd;
  assign rd  = lane_extract(width, off, dout);
endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: memory_bus slave driving a byte-enabled synchronous-read data BRAM.
// Optional misalignment checking is built when DATA_MEM_ALIGN_CHECK_EN is defined.
module data_mem_ctrl
  import mem::*;
  import data_mem_ctrl_pkg::*;
#(
  parameter int          DEPTH_WORDS  = 4096,
  parameter int          READ_LATENCY = 2,
  parameter logic [31:0] BASE_ADDR    = 32'h0
) (
  input  logic                           clk_in,
  input  logic                           rst_n_in,
  mem_bus_if.slave                       mem_bus,
  output logic [$clog2(DEPTH_WORDS)-1:0] bram_addr_out,
  output logic [31:0]                    bram_din_out,
  output logic [3:0]                     bram_we_out,
  input  logic [31:0]                    bram_dout_in,
  output logic                           err_out
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [1:0] LAST = 2'(READ_LATENCY - 1);
  ctrl_state_t state, next;
  logic [AW-1:0] a_waddr;
  logic [1:0] a_off, cnt;
  mem_width_t a_width;
  logic [31:0] a_data, rel, rd, din, rdata;
  logic [3:0] we;
  logic start, ok, a_ok, in_win;
  assign rel    = mem_bus.addr - BASE_ADDR;
  assign in_win = rel < 32'(4 * DEPTH_WORDS);
  assign start  = state == IDLE && (mem_bus.dispatch_read || mem_bus.dispatch_write);
`ifdef DATA_MEM_ALIGN_CHECK_EN
  logic mis;
  assign mis = (mem_bus.mem_width == WORD && mem_bus.addr[0]) ||
               (mem_bus.mem_width == DWORD && mem_bus.addr[1:0] != 2'b00);
  assign ok  = in_win && !mis;
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) err_out <= 1'b0;
    else           err_out <= start && mis;
`else
  assign ok      = in_win;
  assign err_out = 1'b0;
`endif
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) state <= IDLE;
    else           state <= next;
  always_comb begin
    next = state == IDLE      ? (mem_bus.dispatch_write ? WRITE : mem_bus.dispatch_read ? READ_WAIT : IDLE) :
           state == READ_WAIT ? (cnt == LAST ? READ_DONE : READ_WAIT) : IDLE;
  end
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      a_waddr <= '0;
      a_off   <= 2'b00;
      a_width <= BYTE;
      a_data  <= '0;
      a_ok    <= 1'b0;
      cnt     <= 2'b00;
      rdata   <= '0;
    end else begin
      if (start) begin
        a_waddr <= rel[AW+1:2];
        a_off   <= mem_bus.addr[1:0];
        a_width <= mem_bus.mem_width;
        a_data  <= mem_bus.write_data;
        a_ok    <= ok;
        cnt     <= 2'b00;
      end
      if (state == READ_WAIT) cnt <= cnt + 2'd1;
      if (state == READ_DONE) rdata <= a_ok ? rd : 32'h0;
    end
  mem_lane_steer u_steer (
    .width(a_width),
    .off  (a_off),
    .wd   (a_data),
    .dout (bram_dout_in),
    .we   (we),
    .din  (din),
    .rd   (rd)
  );
  // busy must see the dispatch itself: the CPU samples it in the dispatch cycle
  assign mem_bus.busy      = mem_bus.dispatch_read || mem_bus.dispatch_write || state != IDLE;
  assign mem_bus.read_data = rdata;
  assign bram_addr_out     = a_waddr;
  assign bram_din_out      = din;
  assign bram_we_out       = state == WRITE && a_ok ? we : 4'b0000;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: directed checks of data_mem_ctrl against a 2-cycle BRAM model.
module tb_data_mem_ctrl;
  import mem::*;
  logic clk_in = 1'b0;
  logic rst_n_in = 1'b0;
  logic [11:0] bram_addr;
  logic [31:0] bram_din, bram_dout, q1;
  logic [3:0] bram_we;
  logic err;
  logic [31:0] ram [0:4095];
  int we_cnt = 0;
  int passed = 0, total = 0;
  int n;
  logic b0, err1;
  logic [3:0] we1;
  logic [11:0] a1;
  mem_bus_if bus ();
  data_mem_ctrl #(.DEPTH_WORDS(4096), .READ_LATENCY(2), .BASE_ADDR(32'h0)) dut (
    .clk_in       (clk_in),
    .rst_n_in     (rst_n_in),
    .mem_bus      (bus),
    .bram_addr_out(bram_addr),
    .bram_din_out (bram_din),
    .bram_we_out  (bram_we),
    .bram_dout_in (bram_dout),
    .err_out      (err)
  );
  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) begin
    if (|bram_we) begin
      we_cnt <= we_cnt + 1;
      for (int i = 0; i < 4; i++) if (bram_we[i]) ram[bram_addr][8*i +: 8] <= bram_din[8*i +: 8];
    end
    q1 <= ram[bram_addr];
    bram_dout <= q1;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask
  task automatic xfer(input logic wr, input logic [31:0] a, input mem_width_t w, input logic [31:0] d);
    @(negedge clk_in);
    bus.dispatch_write = wr;
    bus.dispatch_read  = !wr;
    bus.addr           = a;
    bus.mem_width      = w;
    bus.write_data     = d;
    #1;
    b0 = bus.busy;
    n  = b0 ? 1 : 0;
    @(negedge clk_in);
    bus.dispatch_write = 1'b0;
    bus.dispatch_read  = 1'b0;
    we1  = bram_we;
    err1 = err;
    a1   = bram_addr;
    while (bus.busy && n < 20) begin
      n++;
      @(negedge clk_in);
    end
  endtask
  initial begin
    int w0;
    bus.dispatch_read  = 1'b0;
    bus.dispatch_write = 1'b0;
    bus.addr           = '0;
    bus.mem_width      = BYTE;
    bus.write_data     = '0;
    repeat (2) @(negedge clk_in);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_rdata", bus.read_data, 0);
    chk("rst_we", 32'(bram_we), 0);
    chk("rst_addr", 32'(bram_addr), 0);
    chk("rst_din", bram_din, 0);
    chk("rst_err", 32'(err), 0);
    rst_n_in = 1'b1;
    xfer(1, 32'h10, DWORD, 32'hDEADBEEF);
    chk("sw_dispatch_busy", 32'(b0), 1);
    chk("sw_busy_cycles", n, 2);
    chk("sw_we", 32'(we1), 32'hF);
    xfer(0, 32'h10, DWORD, 0);
    chk("lw_dispatch_busy", 32'(b0), 1);
    chk("lw_busy_cycles", n, 4);
    chk("lw_addr", 32'(a1), 4);
    chk("lw_data", bus.read_data, 32'hDEADBEEF);
    xfer(1, 32'h10, DWORD, 32'h11223344);
    xfer(1, 32'h13, BYTE, 32'h000000AA);
    chk("sb_we", 32'(we1), 32'b1000);
    xfer(0, 32'h10, DWORD, 0);
    chk("lw_after_sb", bus.read_data, 32'hAA223344);
    xfer(0, 32'h13, BYTE, 0);
    chk("lbu_13", bus.read_data, 32'h000000AA);
    xfer(0, 32'h10, BYTE, 0);
    chk("lbu_10", bus.read_data, 32'h00000044);
    xfer(1, 32'h20, DWORD, 32'h0);
    xfer(1, 32'h22, WORD, 32'h1234BEEF);
    chk("sh_we", 32'(we1), 32'b1100);
    xfer(0, 32'h22, WORD, 0);
    chk("lhu_22", bus.read_data, 32'h0000BEEF);
    xfer(0, 32'h20, DWORD, 0);
    chk("lw_20", bus.read_data, 32'hBEEF0000);
    xfer(0, 32'h20, WORD, 0);
    chk("lhu_20", bus.read_data, 32'h0);
    xfer(1, 32'h0, DWORD, 32'h0BADF00D);
    xfer(0, 32'h10, DWORD, 0);
    w0 = we_cnt;
    xfer(1, 32'h4000, DWORD, 32'h55);
    chk("oow_sw_busy", n, 2);
    chk("oow_sw_nowrite", we_cnt - w0, 0);
    xfer(0, 32'h4000, DWORD, 0);
    chk("oow_lw_busy", n, 4);
    chk("oow_lw_data", bus.read_data, 32'h0);
    xfer(0, 32'h0, DWORD, 0);
    chk("word0_intact", bus.read_data, 32'h0BADF00D);
`ifdef DATA_MEM_ALIGN_CHECK_EN
    xfer(0, 32'h2, DWORD, 0);
    chk("mis_lw_err", 32'(err1), 1);
    chk("mis_lw_busy", n, 4);
    chk("mis_lw_data", bus.read_data, 32'h0);
    w0 = we_cnt;
    xfer(1, 32'h11, WORD, 32'hFFFF);
    chk("mis_sh_err", 32'(err1), 1);
    chk("mis_sh_nowrite", we_cnt - w0, 0);
`else
    xfer(0, 32'h12, DWORD, 0);
    chk("mis_lw_err", 32'(err1), 0);
    chk("mis_lw_data", bus.read_data, 32'hAA223344);
    xfer(0, 32'h13, WORD, 0);
    chk("mis_lhu_data", bus.read_data, 32'h0000AA22);
`endif
    xfer(0, 32'h10, DWORD, 0);
    chk("pre_rst_data", bus.read_data, 32'hAA223344);
    @(negedge clk_in);
    bus.dispatch_read = 1'b1;
    bus.addr          = 32'h10;
    bus.mem_width     = DWORD;
    @(negedge clk_in);
    bus.dispatch_read = 1'b0;
    #2 rst_n_in = 1'b0;
    #1;
    chk("async_rst_busy", 32'(bus.busy), 0);
    chk("async_rst_data", bus.read_data, 0);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    xfer(1, 32'h30, DWORD, 32'h12345678);
    chk("post_rst_sw_busy", n, 2);
    xfer(0, 32'h30, DWORD, 0);
    chk("post_rst_lw_data", bus.read_data, 32'h12345678);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
